// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack port, holds the IR
// for the decoder and picks the next PC from jump/branch/halt and the ALU zero flag.
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [3:0]         op_code,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               jump,
    input  logic               branch,
    input  logic               halt,
    input  logic               alu_zero,
    input  logic               ex_ready,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic [15:0]        retired,
    output logic [1:0]         dbg_state
);

    // Handshake: a fetch completes on the first rising edge where imem_req and
    // imem_ack are both high; imem_addr and imem_req are held until then.
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [15:0]        r_retired;

    logic [PC_W-1:0]    w_pc_inc;
    logic [PC_W-1:0]    w_branch_off;
    logic [PC_W-1:0]    w_next_pc;
    logic [INSTR_W-1:0] w_instr;

    assign w_pc_inc     = r_pc + PC_W'(1);
    assign w_branch_off = {{(PC_W-4){r_ir[3]}}, r_ir[3:0]};

    always_comb begin
        w_next_pc = w_pc_inc;
        if (jump) begin
            w_next_pc = r_ir[PC_W-1:0];
        end else if (branch && alu_zero) begin
            w_next_pc = w_pc_inc + w_branch_off;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_retired <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_rdata;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // halt wins over completion and leaves pc/retired untouched
                    if (halt) begin
                        r_state <= S_HALTED;
                    end else if (ex_ready) begin
                        r_pc      <= w_next_pc;
                        r_retired <= r_retired + 16'd1;
                        r_state   <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    r_state <= S_HALTED;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign w_instr     = rst ? '0 : r_ir;
    assign instr       = w_instr;
    assign op_code     = w_instr[INSTR_W-1 -: 4];
    assign imem_req    = !rst && (r_state == S_FETCH);
    assign instr_valid = !rst && (r_state == S_EXEC);
    assign halted      = !rst && (r_state == S_HALTED);
    assign imem_addr   = rst ? RESET_PC : r_pc;
    assign pc          = r_pc;
    assign retired     = r_retired;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model of the fetch/execute/halt behaviour.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [3:0]  op_code;
  logic [15:0] instr;
  logic        instr_valid;
  logic        jump = 1'b0, branch = 1'b0, halt = 1'b0, alu_zero = 1'b0, ex_ready = 1'b0;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] retired;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .op_code(op_code), .instr(instr), .instr_valid(instr_valid),
    .jump(jump), .branch(branch), .halt(halt), .alu_zero(alu_zero), .ex_ready(ex_ready),
    .pc(pc), .halted(halted), .retired(retired), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: phase 0=fetching, 1=executing, 2=stopped
  int          m_phase = 0;
  int          m_pc = 0;
  int          m_ir = 0;
  int          m_ret = 0;
  bit          m_live = 0;
  logic [15:0] exp_q[$];

  function automatic int target_pc(int cur_pc, int ir, bit j, bit b, bit z);
    int off;
    int t;
    if (j) return ir % 256;
    t = cur_pc + 1;
    if (b && z) begin
      off = ir % 16;
      if (off > 7) off = off - 16;
      t = t + off;
    end
    return ((t % 256) + 256) % 256;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_pc = 0; m_ir = 0; m_ret = 0;
      exp_q.delete();
    end else if (m_phase == 0) begin
      if (imem_ack) begin
        m_ir = int'(imem_rdata);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (halt) begin
        m_phase = 2;
      end else if (ex_ready) begin
        m_pc = target_pc(m_pc, m_ir, jump, branch, alu_zero);
        m_ret = (m_ret + 1) % 65536;
        exp_q.push_back(16'(m_pc));
        m_phase = 0;
      end
    end
    m_live = 1;
  end

  // scoreboard: per-cycle compare away from the active edge
  always @(negedge clk) begin
    if (m_live) begin
      chk("imem_req", imem_req, !rst && m_phase == 0);
      chk("instr_valid", instr_valid, !rst && m_phase == 1);
      chk("halted", halted, !rst && m_phase == 2);
      chk("imem_addr", imem_addr, rst ? 0 : m_pc);
      chk("instr", instr, rst ? 0 : m_ir);
      chk("op_code", op_code, rst ? 0 : (m_ir / 4096));
      chk("pc", pc, m_pc);
      chk("retired", retired, m_ret);
      if (!rst && imem_req && exp_q.size() > 0) begin
        chk("fetch_addr_after_retire", imem_addr, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic cyc(input bit r, input bit ack, input logic [15:0] d,
                     input bit j, input bit b, input bit h, input bit z, input bit exr);
    rst = r; imem_ack = ack; imem_rdata = d;
    jump = j; branch = b; halt = h; alu_zero = z; ex_ready = exr;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_noise_fetch(input bit ack, input logic [15:0] d);
    cyc(1'b0, ack, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic run_instr(input int waits, input logic [15:0] d,
                           input bit j, input bit b, input bit z, input int ex_waits);
    for (int i = 0; i < waits; i++) cyc_noise_fetch(1'b0, 16'($urandom));
    cyc_noise_fetch(1'b1, d);
    for (int i = 0; i < ex_waits; i++)
      cyc(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), j, b, 1'b0, z, 1'b0);
    cyc(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), j, b, 1'b0, z, 1'b1);
    imem_ack = 1'b0;
  endtask

  initial begin
    // reset held 3 cycles with ack high
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("reset_req_low", imem_req, 0);
    end
    chk("reset_pc", pc, 8'h00);
    chk("reset_retired", retired, 0);
    rst = 1'b0; imem_ack = 1'b0;
    #1;
    chk("release_req", imem_req, 1);
    chk("release_addr", imem_addr, 8'h00);

    // sequential with 2 memory waits and 1 ex_ready stall
    run_instr(2, 16'h0123, 1'b0, 1'b0, 1'b0, 1);
    chk("seq_pc", pc, 8'h01);
    chk("seq_retired", retired, 1);

    // branch taken / not taken / jump priority
    run_instr(0, 16'h8005, 1'b1, 1'b0, 1'b0, 0);
    run_instr(0, 16'h201E, 1'b0, 1'b1, 1'b1, 0);
    chk("beq_taken_addr", imem_addr, 8'h04);
    run_instr(0, 16'h8005, 1'b1, 1'b0, 1'b0, 0);
    run_instr(1, 16'h201E, 1'b0, 1'b1, 1'b0, 2);
    chk("beq_not_taken_addr", imem_addr, 8'h06);
    run_instr(0, 16'h8020, 1'b1, 1'b1, 1'b1, 0);
    chk("jump_wins_addr", imem_addr, 8'h20);

    // wrap cases
    run_instr(0, 16'h80FF, 1'b1, 1'b0, 1'b0, 0);
    run_instr(0, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
    chk("wrap_inc_addr", imem_addr, 8'h00);
    run_instr(0, 16'h2018, 1'b0, 1'b1, 1'b1, 0);
    chk("wrap_back_addr", imem_addr, 8'hF9);

    // halt at 0x10 without ex_ready
    run_instr(0, 16'h8010, 1'b1, 1'b0, 1'b0, 0);
    cyc_noise_fetch(1'b1, 16'hF000);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("halt_halted", halted, 1);
    chk("halt_pc", pc, 8'h10);
    chk("halt_retired", retired, 10);
    for (int i = 0; i < 20; i++) begin
      cyc_noise_fetch(1'(i % 2), 16'($urandom));
      chk("halt_req_low", imem_req, 0);
    end
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("restart_addr", imem_addr, 8'h00);
    chk("restart_req", imem_req, 1);

    // reset while waiting for ack at 0x33, with a late ack in the reset cycle
    run_instr(0, 16'h8033, 1'b1, 1'b0, 1'b0, 0);
    cyc_noise_fetch(1'b0, 16'h0);
    cyc_noise_fetch(1'b0, 16'h0);
    chk("midfetch_addr", imem_addr, 8'h33);
    cyc(1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0; imem_ack = 1'b0;
    #1;
    chk("midfetch_ir", instr, 0);
    chk("midfetch_pc", pc, 8'h00);
    chk("midfetch_retired", retired, 0);
    chk("midfetch_no_exec", instr_valid, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)), 16'($urandom),
          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 4) < 3));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
